// File: rtl/traffic_phase_controller.sv
// Multi-phase signal controller: green/yellow/all-red sequencing with demand-based phase
// skipping, latched pedestrian walk requests and a flashing-red fail-safe mode.
module traffic_phase_controller #(
    parameter int unsigned NUM_PHASES = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tick,
    input  logic [CNT_W-1:0]              green_time,
    input  logic [CNT_W-1:0]              yellow_time,
    input  logic [CNT_W-1:0]              allred_time,
    input  logic [NUM_PHASES-1:0]         veh_req,
    input  logic [NUM_PHASES-1:0]         ped_req,
    input  logic                          flash,
    output logic [NUM_PHASES-1:0]         red,
    output logic [NUM_PHASES-1:0]         yellow,
    output logic [NUM_PHASES-1:0]         green,
    output logic [NUM_PHASES-1:0]         walk,
    output logic [$clog2(NUM_PHASES)-1:0] phase,
    output logic                          flash_active
);

    localparam int unsigned PW = $clog2(NUM_PHASES);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [NUM_PHASES-1:0] ONE_HOT0 = NUM_PHASES'(1);

    typedef enum logic [1:0] {StAllRed, StGreen, StYellow, StFlash} state_e;

    state_e                  state_q;
    logic [PW-1:0]           phase_q;
    logic [PW-1:0]           next_phase_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        dur_q;
    logic                    fresh_q;
    logic [NUM_PHASES-1:0]   ped_pending_q;
    logic [NUM_PHASES-1:0]   red_q;
    logic [NUM_PHASES-1:0]   yellow_q;
    logic [NUM_PHASES-1:0]   green_q;
    logic [NUM_PHASES-1:0]   walk_q;
    logic                    flash_active_q;
    logic                    blink_q;

    logic [NUM_PHASES-1:0]   demand;
    logic                    found;
    logic [PW-1:0]           found_idx;
    logic [PW-1:0]           cand;
    logic [CNT_W-1:0]        lim;
    logic [CNT_W-1:0]        lim_m1;
    logic                    expire;
    logic                    green_load;
    logic [PW-1:0]           load_phase;
    logic                    entry_walk;
    logic [NUM_PHASES-1:0]   ped_clr;
    logic [NUM_PHASES-1:0]   ped_pending_d;
    logic [NUM_PHASES-1:0]   phase_oh;
    logic [NUM_PHASES-1:0]   next_oh;

    assign demand   = veh_req | ped_pending_q;
    assign phase_oh = ONE_HOT0 << phase_q;
    assign next_oh  = ONE_HOT0 << next_phase_q;

    // Round-robin search for the first other phase with demand, starting after phase_q.
    always_comb begin
        found     = 1'b0;
        found_idx = phase_q;
        cand      = '0;
        for (int unsigned k = 1; k < NUM_PHASES; k++) begin
            cand = PW'((32'(phase_q) + k) % NUM_PHASES);
            if (!found && demand[cand]) begin
                found     = 1'b1;
                found_idx = cand;
            end
        end
    end

    // The very first all-red has no sampled duration yet, so it uses the live input.
    always_comb begin
        lim    = fresh_q ? allred_time : dur_q;
        lim_m1 = (lim == '0) ? '0 : lim - ONE;
        expire = tick && (cnt_q == lim_m1);
    end

    always_comb begin
        green_load = 1'b0;
        load_phase = phase_q;
        if (expire && !flash) begin
            if (state_q == StAllRed) begin
                green_load = 1'b1;
                load_phase = next_phase_q;
            end else if (state_q == StGreen && !found) begin
                green_load = 1'b1;
                load_phase = phase_q;
            end
        end
        entry_walk    = ped_pending_q[load_phase];
        ped_clr       = green_load ? (ONE_HOT0 << load_phase) : '0;
        // A new button press in the same cycle as the clear keeps the request pending.
        ped_pending_d = (ped_pending_q & ~ped_clr) | ped_req;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StAllRed;
            phase_q        <= '0;
            next_phase_q   <= '0;
            cnt_q          <= '0;
            dur_q          <= '0;
            fresh_q        <= 1'b1;
            ped_pending_q  <= '0;
            red_q          <= '1;
            yellow_q       <= '0;
            green_q        <= '0;
            walk_q         <= '0;
            flash_active_q <= 1'b0;
            blink_q        <= 1'b0;
        end else begin
            ped_pending_q <= ped_pending_d;
            if (tick) begin
                unique case (state_q)
                    StAllRed: begin
                        if (expire) begin
                            fresh_q <= 1'b0;
                            cnt_q   <= '0;
                            if (flash) begin
                                state_q        <= StFlash;
                                blink_q        <= 1'b1;
                                red_q          <= '1;
                                flash_active_q <= 1'b1;
                            end else begin
                                state_q <= StGreen;
                                phase_q <= next_phase_q;
                                dur_q   <= green_time;
                                green_q <= next_oh;
                                red_q   <= ~next_oh;
                                walk_q  <= entry_walk ? next_oh : '0;
                            end
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    StGreen: begin
                        if (flash || (expire && found)) begin
                            state_q      <= StYellow;
                            cnt_q        <= '0;
                            dur_q        <= yellow_time;
                            green_q      <= '0;
                            yellow_q     <= phase_oh;
                            walk_q       <= '0;
                            next_phase_q <= found_idx;
                        end else if (expire) begin
                            // Nobody else is waiting: rest in green with a fresh interval.
                            cnt_q  <= '0;
                            dur_q  <= green_time;
                            walk_q <= entry_walk ? phase_oh : '0;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    StYellow: begin
                        if (expire) begin
                            state_q  <= StAllRed;
                            cnt_q    <= '0;
                            dur_q    <= allred_time;
                            yellow_q <= '0;
                            red_q    <= '1;
                        end else begin
                            cnt_q <= cnt_q + ONE;
                        end
                    end
                    StFlash: begin
                        if (!flash) begin
                            state_q        <= StAllRed;
                            cnt_q          <= '0;
                            dur_q          <= allred_time;
                            red_q          <= '1;
                            blink_q        <= 1'b0;
                            flash_active_q <= 1'b0;
                            next_phase_q   <= '0;
                        end else begin
                            blink_q <= ~blink_q;
                            red_q   <= {NUM_PHASES{~blink_q}};
                        end
                    end
                endcase
            end
        end
    end

    assign red          = red_q;
    assign yellow       = yellow_q;
    assign green        = green_q;
    assign walk         = walk_q;
    assign phase        = phase_q;
    assign flash_active = flash_active_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Scoreboard bench for traffic_phase_controller: each step queues its stimulus with the
// lamp/walk/phase vector expected after that tick.
module tb_traffic_phase_controller;

    logic       clk;
    logic       reset;
    logic       tick;
    logic [7:0] green_time;
    logic [7:0] yellow_time;
    logic [7:0] allred_time;
    logic [3:0] veh_req;
    logic [3:0] ped_req;
    logic       flash;
    logic [3:0] red;
    logic [3:0] yellow;
    logic [3:0] green;
    logic [3:0] walk;
    logic [1:0] phase;
    logic       flash_active;
    logic [20:0] obs;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [3:0]  pv;
        logic [3:0]  veh;
        logic        fl;
        logic [20:0] exp;
    } step_t;

    step_t sb[$];

    traffic_phase_controller #(
        .NUM_PHASES(4),
        .CNT_W     (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .green_time  (green_time),
        .yellow_time (yellow_time),
        .allred_time (allred_time),
        .veh_req     (veh_req),
        .ped_req     (ped_req),
        .flash       (flash),
        .red         (red),
        .yellow      (yellow),
        .green       (green),
        .walk        (walk),
        .phase       (phase),
        .flash_active(flash_active)
    );

    assign obs = {red, yellow, green, walk, phase, flash_active};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] oh(input int p);
        logic [3:0] one;
        one = 4'b0001;
        return one << p;
    endfunction

    function automatic logic [20:0] e_green(input int p, input bit w);
        return {~oh(p), 4'b0000, oh(p), (w ? oh(p) : 4'b0000), 2'(p), 1'b0};
    endfunction

    function automatic logic [20:0] e_yellow(input int p);
        return {~oh(p), oh(p), 4'b0000, 4'b0000, 2'(p), 1'b0};
    endfunction

    function automatic logic [20:0] e_allred(input int p);
        return {4'b1111, 12'h000, 2'(p), 1'b0};
    endfunction

    function automatic logic [20:0] e_flash(input int p, input logic b);
        return {{4{b}}, 12'h000, 2'(p), 1'b1};
    endfunction

    function automatic void push(input logic [3:0] pv, input logic [3:0] veh, input logic fl,
                                 input logic [20:0] e, input int n = 1);
        step_t st;
        st.pv  = pv;
        st.veh = veh;
        st.fl  = fl;
        st.exp = e;
        for (int i = 0; i < n; i++) sb.push_back(st);
    endfunction

    // One tick cycle followed by one idle cycle; returns #1 after the idle edge.
    task automatic tick_once(input logic [3:0] pv);
        ped_req = pv;
        tick    = 1'b1;
        @(posedge clk);
        #1;
        tick    = 1'b0;
        ped_req = 4'b0000;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] g, input logic [7:0] y, input logic [7:0] a,
                            input logic [3:0] veh);
        reset       = 1'b1;
        tick        = 1'b0;
        ped_req     = 4'b0000;
        flash       = 1'b0;
        veh_req     = veh;
        green_time  = g;
        yellow_time = y;
        allred_time = a;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset(8'd3, 8'd2, 8'd1, 4'b1111);
        vectors++;
        if (obs !== e_allred(0)) begin
            miscompares++;
            $display("FAIL reset: got %h expected %h", obs, e_allred(0));
        end
    endtask

    task automatic test_sequence();
        step_t st;
        int k = 0;
        do_reset(8'd3, 8'd2, 8'd1, 4'b1111);
        for (int p = 0; p < 4; p++) begin
            push(4'b0, 4'b1111, 1'b0, e_green(p, 1'b0), 3);
            push(4'b0, 4'b1111, 1'b0, e_yellow(p), 2);
            push(4'b0, 4'b1111, 1'b0, e_allred(p), 1);
        end
        push(4'b0, 4'b1111, 1'b0, e_green(0, 1'b0), 3);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            veh_req = st.veh;
            flash   = st.fl;
            tick_once(st.pv);
            vectors++;
            if (obs !== st.exp) begin
                miscompares++;
                $display("FAIL sequence step %0d: got %h expected %h", k, obs, st.exp);
            end
            k++;
        end
    endtask

    task automatic test_skip();
        step_t st;
        int k = 0;
        do_reset(8'd3, 8'd2, 8'd1, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            push(4'b0, 4'b0101, 1'b0, e_green((i % 2) * 2, 1'b0), 3);
            push(4'b0, 4'b0101, 1'b0, e_yellow((i % 2) * 2), 2);
            push(4'b0, 4'b0101, 1'b0, e_allred((i % 2) * 2), 1);
        end
        push(4'b0, 4'b0101, 1'b0, e_green(2, 1'b0), 3);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            veh_req = st.veh;
            flash   = st.fl;
            tick_once(st.pv);
            vectors++;
            if (obs !== st.exp) begin
                miscompares++;
                $display("FAIL skip step %0d: got %h expected %h", k, obs, st.exp);
            end
            k++;
        end
    endtask

    task automatic test_rest();
        step_t st;
        int k = 0;
        do_reset(8'd3, 8'd2, 8'd1, 4'b0001);
        push(4'b0, 4'b0001, 1'b0, e_green(0, 1'b0), 10);
        push(4'b0, 4'b0101, 1'b0, e_green(0, 1'b0), 2);
        push(4'b0, 4'b0101, 1'b0, e_yellow(0), 2);
        push(4'b0, 4'b0101, 1'b0, e_allred(0), 1);
        push(4'b0, 4'b0101, 1'b0, e_green(2, 1'b0), 3);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            veh_req = st.veh;
            flash   = st.fl;
            tick_once(st.pv);
            vectors++;
            if (obs !== st.exp) begin
                miscompares++;
                $display("FAIL rest step %0d: got %h expected %h", k, obs, st.exp);
            end
            k++;
        end
    endtask

    task automatic test_ped();
        step_t st;
        int k = 0;
        do_reset(8'd3, 8'd2, 8'd1, 4'b1000);
        push(4'b0, 4'b1000, 1'b0, e_green(0, 1'b0), 3);
        push(4'b0, 4'b1000, 1'b0, e_yellow(0), 2);
        push(4'b0, 4'b1000, 1'b0, e_allred(0), 1);
        push(4'b0, 4'b1000, 1'b0, e_green(3, 1'b0), 1);
        push(4'b0010, 4'b0000, 1'b0, e_green(3, 1'b0), 1);
        push(4'b0, 4'b0000, 1'b0, e_green(3, 1'b0), 1);
        push(4'b0, 4'b0000, 1'b0, e_yellow(3), 2);
        push(4'b0, 4'b0000, 1'b0, e_allred(3), 1);
        // Press on the green-entry tick survives the clear and re-arms walk on the rest.
        push(4'b0010, 4'b0000, 1'b0, e_green(1, 1'b1), 1);
        push(4'b0, 4'b0000, 1'b0, e_green(1, 1'b1), 5);
        push(4'b0, 4'b0001, 1'b0, e_yellow(1), 2);
        push(4'b0, 4'b0001, 1'b0, e_allred(1), 1);
        push(4'b0, 4'b0001, 1'b0, e_green(0, 1'b0), 1);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            veh_req = st.veh;
            flash   = st.fl;
            tick_once(st.pv);
            vectors++;
            if (obs !== st.exp) begin
                miscompares++;
                $display("FAIL ped step %0d: got %h expected %h", k, obs, st.exp);
            end
            k++;
        end
    endtask

    task automatic test_flash();
        step_t st;
        int k = 0;
        do_reset(8'd10, 8'd2, 8'd2, 4'b0100);
        push(4'b0, 4'b0100, 1'b0, e_allred(0), 1);
        push(4'b0, 4'b0100, 1'b0, e_green(0, 1'b0), 10);
        push(4'b0, 4'b0100, 1'b0, e_yellow(0), 2);
        push(4'b0, 4'b0100, 1'b0, e_allred(0), 2);
        push(4'b0, 4'b0100, 1'b0, e_green(2, 1'b0), 2);
        push(4'b0, 4'b0100, 1'b1, e_yellow(2), 2);
        push(4'b0, 4'b0100, 1'b1, e_allred(2), 2);
        push(4'b0, 4'b0100, 1'b1, e_flash(2, 1'b1), 1);
        push(4'b0, 4'b0100, 1'b1, e_flash(2, 1'b0), 1);
        push(4'b0, 4'b0100, 1'b1, e_flash(2, 1'b1), 1);
        push(4'b0, 4'b0100, 1'b0, e_allred(2), 2);
        push(4'b0, 4'b0100, 1'b0, e_green(0, 1'b0), 1);
        while (sb.size() > 0) begin
            st = sb.pop_front();
            veh_req = st.veh;
            flash   = st.fl;
            tick_once(st.pv);
            vectors++;
            if (obs !== st.exp) begin
                miscompares++;
                $display("FAIL flash step %0d: got %h expected %h", k, obs, st.exp);
            end
            k++;
        end
        flash = 1'b0;
    endtask

    task automatic test_zero_and_reset();
        step_t st;
        int k = 0;
        do_reset(8'd0, 8'd0, 8'd1, 4'b1111);
        for (int p = 0; p < 3; p++) begin
            push(4'b0, 4'b1111, 1'b0, e_green(p, 1'b0), 1);
            push(4'b0, 4'b1111, 1'b0, e_yellow(p), 1);
            if (p < 2) push((p == 1) ? 4'b1000 : 4'b0000, 4'b1111, 1'b0, e_allred(p), 1);
        end
        while (sb.size() > 0) begin
            st = sb.pop_front();
            veh_req = st.veh;
            flash   = st.fl;
            tick_once(st.pv);
            vectors++;
            if (obs !== st.exp) begin
                miscompares++;
                $display("FAIL zero step %0d: got %h expected %h", k, obs, st.exp);
            end
            k++;
        end
        // Mid-yellow on phase 2, away from any clock edge.
        reset = 1'b1;
        #2;
        vectors++;
        if (obs !== e_allred(0)) begin
            miscompares++;
            $display("FAIL async_reset: got %h expected %h", obs, e_allred(0));
        end
        reset   = 1'b0;
        veh_req = 4'b0001;
        // A surviving phase-3 ped request would pull phase 0 into yellow.
        push(4'b0, 4'b0001, 1'b0, e_green(0, 1'b0), 3);
        k = 0;
        while (sb.size() > 0) begin
            st = sb.pop_front();
            veh_req = st.veh;
            flash   = st.fl;
            tick_once(st.pv);
            vectors++;
            if (obs !== st.exp) begin
                miscompares++;
                $display("FAIL post_reset step %0d: got %h expected %h", k, obs, st.exp);
            end
            k++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        tick        = 1'b0;
        ped_req     = 4'b0000;
        veh_req     = 4'b0000;
        flash       = 1'b0;
        green_time  = 8'd3;
        yellow_time = 8'd2;
        allred_time = 8'd1;
        test_reset();
        test_sequence();
        test_skip();
        test_rest();
        test_ped();
        test_flash();
        test_zero_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/traffic_phase_controller.md
# traffic_phase_controller

Parametrised multi-phase signal controller that sequences NUM_PHASES conflicting approaches through green, yellow and all-red clearance. It adds demand-based phase skipping, latched pedestrian walk requests and a flashing-red fail-safe mode. It sits behind the tick prescaler in the intersection top level and drives the lamp and walk driver registers directly.

## Interface
- NUM_PHASES, 4, number of conflicting phases; legal range 2..8
- CNT_W, 8, width of duration inputs and the tick counter
- reset  in  1  asynchronous, active-high
- clk  in  1  system clock
- tick  in  1  one-cycle timebase pulse; all timing advances only on cycles with tick=1
- green_time  in  CNT_W  green duration in ticks; sampled on GREEN entry; 0 is treated as 1
- yellow_time  in  CNT_W  yellow duration in ticks; sampled on YELLOW entry; 0 is treated as 1
- allred_time  in  CNT_W  all-red clearance in ticks; sampled on ALLRED entry; 0 is treated as 1
- veh_req  in  NUM_PHASES  level vehicle demand per phase
- ped_req  in  NUM_PHASES  pedestrian button pulse per phase; latched internally
- flash  in  1  level request for the fail-safe flashing mode
- red, yellow, green  out  NUM_PHASES  per-phase lamp drives
- walk  out  NUM_PHASES  per-phase walk signal
- phase  out  $clog2(NUM_PHASES)  index of the current or last-served phase
- flash_active  out  1  high while in FLASH

## Operation
- States: ALLRED, GREEN, YELLOW, FLASH. Counter cnt counts ticks within a state and clears on every state change.
- A state expires on a tick where cnt == max(dur,1)-1.
- Reset: state=ALLRED, phase=0, cnt=0, ped_pending=0, red=all 1, yellow=0, green=0, walk=0, flash_active=0, flash blink bit=0.
- ALLRED: all red=1. On expiry, if flash=1, go to FLASH. Otherwise go to GREEN on next_phase. The first ALLRED after reset always selects phase 0.
- GREEN: green[phase]=1; all other phases red=1. walk[phase]=1 for the whole green if ped_pending[phase] was set on the entry cycle. That ped_pending bit clears on the entry cycle.
- Demand for phase i = veh_req[i] | ped_pending[i].
- Green expiry: search phases phase+1 .. phase+NUM_PHASES-1 modulo NUM_PHASES. The first phase with demand becomes next_phase, and the state goes to YELLOW.
  - If no other phase has demand, stay in GREEN, reload green_time and restart cnt (rest in green).
  - If ped_pending[phase] is set at that point, walk for the restarted green is re-evaluated as on entry.
- flash=1 during GREEN: force YELLOW at the next tick (green is cut short, minimum 1 tick), regardless of demand.
- YELLOW: yellow[phase]=1, walk=0. On expiry go to ALLRED.
- FLASH:
  - All yellow, green and walk are 0. All red bits equal a blink bit that toggles every tick (starts at 1 on entry).
  - ped_pending still latches.
  - When flash=0 on a tick, go to ALLRED and then phase 0.
- flash=1 seen in ALLRED or YELLOW does not shorten those states. The transition to FLASH happens at the end of ALLRED; YELLOW proceeds to ALLRED first.
- ped_pending[i] sets on any cycle with ped_req[i]=1. If a set and a clear hit the same bit in the same cycle, the set wins and the request stays pending.
- Invariant: at most one green bit is set, and never in the same cycle as any yellow bit of another phase.

## Timing
- All outputs are registered and change only on the clk edge where the state changes or blinks.
- Outputs change in the cycle after the qualifying tick.
- Durations are exact: green_time=G gives green high for exactly G ticks.
- Full cycle for phase i: green G, yellow Y, all-red A ticks.
- Inputs are synchronous to clk. veh_req and flash are sampled only on tick cycles. ped_req is sampled every cycle.
- Reset may assert at any time. It takes effect asynchronously: outputs go to all-red immediately and all latched requests are lost.

## Test plan
- Reset with G=3, Y=2, A=1, veh_req=4'b1111 -> all-red 1 tick, then phases 0,1,2,3,0 in order, each green 3 / yellow 2 / all-red 1 tick.
- veh_req=4'b0101 only -> phases 0 and 2 alternate; phases 1 and 3 never leave red.
- veh_req=4'b0001, no other demand -> phase 0 rests in green indefinitely. Assert veh_req[2] -> after the current green expires, yellow 0 then green 2.
- ped_req[1] pulse while phase 3 is green, no vehicle demand -> phase 1 served with walk[1]=1 for all G ticks and 0 in yellow. A ped_req[1] pulse on the GREEN entry cycle leaves ped_pending[1]=1.
- flash=1 mid-green on phase 2 with G=10 -> yellow next tick, then all-red, then red toggling each tick with flash_active=1. flash=0 -> all-red A ticks, then green on phase 0.
- green_time=0 and yellow_time=0 -> each treated as 1 tick. Reset asserted mid-yellow -> immediate all-red, phase=0, walk=0.
